// File: rtl/mux21_arb_pkg.sv
// Shared types for the two-requester packet arbiter: FSM state encoding and
// the width of the stall counter that bounds idle time inside a grant.
package mux21_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux21_bus.sv
// W-bit 2:1 multiplexer; i_s=0 selects i_a, i_s=1 selects i_b.
module mux21_bus #(
  parameter int W = 8
) (
  input  logic         i_s,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = i_s ? i_b : i_a;

endmodule

// File: rtl/mux21_arbiter.sv
// Two-requester packet arbiter: locks the shared output to one requester
// until its last beat transfers or the grant has stalled for MAX_IDLE cycles.
//
// Handshake: a beat moves on y when y_valid && y_ready in the same cycle;
// valid never depends on ready, and the granted side's ready is y_ready.
module mux21_arbiter
  import mux21_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_IDLE = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          a_last,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic          b_last,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          y_valid,
  output logic          y_last,
  output logic [DW-1:0] y_data,
  input  logic          y_ready,
  output logic          s,
  output logic          timeout,
  output state_t        o_dbg_state
);

  state_t             r_state;
  logic               r_prio_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_s;
  logic               r_timeout;

  logic               w_granted;
  logic               w_g_valid;
  logic               w_xfer;
  logic [DW-1:0]      w_data;
  logic [0:0]         w_last;

  mux21_bus #(.W(DW)) u_data_mux (
    .i_s (r_s),
    .i_a (a_data),
    .i_b (b_data),
    .o_y (w_data)
  );

  mux21_bus #(.W(1)) u_last_mux (
    .i_s (r_s),
    .i_a (a_last),
    .i_b (b_last),
    .o_y (w_last)
  );

  // r_s always matches the grant while granted, so it doubles as the source select.
  assign w_granted = (r_state != ST_IDLE);
  assign w_g_valid = r_s ? b_valid : a_valid;
  assign w_xfer    = y_valid && y_ready;

  assign y_valid     = w_granted && w_g_valid;
  assign y_last      = w_granted && w_last[0];
  assign y_data      = w_granted ? w_data : '0;
  assign a_ready     = (r_state == ST_GNT_A) && y_ready;
  assign b_ready     = (r_state == ST_GNT_B) && y_ready;
  assign s           = r_s;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_prio_b  <= 1'b0;
      r_cnt     <= '0;
      r_s       <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (a_valid && (!b_valid || !r_prio_b)) begin
            r_state <= ST_GNT_A;
            r_s     <= 1'b0;
          end else if (b_valid) begin
            r_state <= ST_GNT_B;
            r_s     <= 1'b1;
          end
        end
        ST_GNT_A, ST_GNT_B: begin
          if (w_xfer) begin
            r_cnt <= '0;
            if (y_last) begin
              r_state  <= ST_IDLE;
              r_prio_b <= (r_state == ST_GNT_A);
            end
          end else if (!w_g_valid) begin
            // Backpressure (valid high, ready low) leaves the counter untouched.
            if (r_cnt == CNT_W'(MAX_IDLE - 1)) begin
              r_state   <= ST_IDLE;
              r_cnt     <= '0;
              r_timeout <= 1'b1;
              r_prio_b  <= (r_state == ST_GNT_A);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux21_arbiter.md
MUX21_ARBITER -- requirements
Module: mux21_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of each requester and of the output.
REQ-002 Parameter MAX_IDLE, default 15: stall cycles allowed inside a granted packet before forced release; range 1..255.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 a_valid, a_last  input  1 each  requester A beat valid, last beat of packet.
REQ-006 a_data  input  DW  requester A beat data.
REQ-007 a_ready  output  1  requester A beat accepted.
REQ-008 b_valid, b_last, b_data, b_ready: as REQ-005..007, for requester B.
REQ-009 y_valid, y_last  output  1 each  shared-output beat valid, last.
REQ-010 y_data  output  DW  shared-output data.
REQ-011 y_ready  input  1  downstream accepts beat.
REQ-012 s  output  1  mux select, 0 = A, 1 = B.
REQ-013 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 States: IDLE, GNT_A, GNT_B.
REQ-015 IDLE: y_valid=0, a_ready=b_ready=0, s holds its last value.
REQ-016 IDLE, only A valid -> GNT_A next cycle; only B valid -> GNT_B next cycle.
REQ-017 IDLE, both valid -> grant the requester not served last (pointer); after reset the pointer favours A.
REQ-018 Arbitration latency: exactly 1 cycle, IDLE to first beat presented.
REQ-019 GNT_A: s=0; y_valid/y_data/y_last = a_valid/a_data/a_last; a_ready=y_ready; b_ready=0. GNT_B is symmetric with s=1.
REQ-020 A beat transfers when y_valid && y_ready.
REQ-021 Transfer with y_last=1 -> IDLE next cycle; pointer records the served requester.
REQ-022 Grant stays locked mid-packet; the other requester never preempts.
REQ-023 Stall counter: increments each granted cycle with granted valid=0; clears on any transfer and on grant entry.
REQ-024 Counter reaching MAX_IDLE -> IDLE next cycle, timeout=1 for that one cycle, pointer records the released requester.
REQ-025 Downstream backpressure (valid=1, y_ready=0) does not count as a stall and never triggers a timeout.
REQ-026 Single-beat packet (valid and last in the first granted cycle, y_ready=1) -> back to IDLE after 1 beat; total 2 cycles per packet, no bubble beyond the IDLE cycle.
REQ-027 Data and last are not registered; the combinational path runs from the granted input to y_*.

Reset
REQ-028 rst=1 -> state=IDLE, pointer favours A, stall counter=0, s=0, timeout=0, y_valid=0, a_ready=b_ready=0.
REQ-029 rst asserted mid-packet aborts the grant without completing the packet; the first post-reset arbitration follows REQ-016/017.

Structure
REQ-030 Package mux21_arb_pkg holds the state enum and the stall-counter width constant (8).
REQ-031 One sub-module: mux21_bus, a DW-wide 2:1 mux (s=0 selects a), instanced for data and for last.

Verification
REQ-032 Reset: rst high 2 cycles -> all outputs 0, s=0, state IDLE.
REQ-033 Both requesters post 1-beat packets continuously, y_ready=1 -> grants alternate A,B,A,B; y_data follows a_data=8'h11, b_data=8'h22 alternately.
REQ-034 A sends a 4-beat packet while B is valid -> B waits; b_ready=0 until 1 cycle after A's last beat transfers.
REQ-035 A is granted, then a_valid=0 for 15 cycles -> timeout pulses once; B is granted on the next arbitration.
REQ-036 Granted A with y_ready=0 for 40 cycles -> no timeout; the beat transfers when y_ready rises.
REQ-037 rst pulsed mid-packet of B -> IDLE next cycle; a following simultaneous request grants A.
